mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Data-memory interface for the M stage; it carries store data out to the data bus and load data back in.
- Store path narrows register data into byte lanes. It generates byte enables and replicates the data across lanes.
- Load path selects the addressed byte or halfword from the returned word, then sign- or zero-extends it to 32 bits.
- Runs a req/ack bus handshake with a timeout, and stalls the pipeline until each access resolves.

Parameters:
- MAX_WAIT, 255: bus cycles allowed without bus_ack before the access is aborted with an error (1..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  M stage holds a load or store.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  load zero-extends when 1 (lbu/lhu); ignored for stores.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data (rt value).
- req_stall  output  1  freeze the pipeline at or before M.
- rsp_valid  output  1  one-cycle pulse; the access has completed.
- rsp_rdata  output  32  extended load data, valid with rsp_valid.
- rsp_err  output  1  misaligned, reserved-size or timeout; valid with rsp_valid.
- bus_req  output  1  bus request.
- bus_we  output  1  bus write.
- bus_addr  output  32  word address, bits [1:0] = 00.
- bus_be  output  4  byte enables; bit k covers bits [8k+7:8k].
- bus_wdata  output  32  lane-replicated store data.
- bus_ack  input  1  bus completes the current request this cycle.
- bus_rdata  input  32  read word, valid when bus_ack = 1 and bus_we = 0.

Behaviour:
- States: IDLE, BUS, RESP. All outputs except req_stall are registered.
- Reset (reset = 0 at an edge):
  - State goes to IDLE; wait counter and every registered output go to 0.
  - Reset during BUS: bus_req drops at that edge, and no rsp_valid is ever produced for the aborted access.
- IDLE, with req_valid = 1 at an edge:
  - Latch the request fields.
  - Error cases: size 11, half with addr[0] = 1, word with addr[1:0] != 00. These go directly to RESP with err = 1 and no bus cycle.
  - Otherwise go to BUS with bus_req = 1.
- BUS:
  - bus_req, bus_we, bus_addr, bus_be and bus_wdata are held stable until bus_ack.
  - On bus_ack: capture bus_rdata, clear the counter, drop bus_req, go to RESP.
  - Each BUS cycle without ack increments the counter. When the counter reaches MAX_WAIT with no ack: drop bus_req, set err = 1, go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then return to IDLE.
  - A new request is accepted from IDLE no earlier than the following edge.
- req_stall = req_valid AND (state != RESP), combinational.
  - Best-case latency with ack on the first BUS cycle: stall for 2 cycles, rsp_valid in the 3rd cycle.
  - Error cases in IDLE: stall for 1 cycle.
- Store lane mapping (little-endian):
  - Byte: bus_be = 0001 << addr[1:0]; bus_wdata = wdata[7:0] replicated 4 times.
  - Half: bus_be = 0011 if addr[1] = 0, else 1100; bus_wdata = wdata[15:0] replicated twice.
  - Word: bus_be = 1111; bus_wdata = wdata.
- Loads: bus_be = 1111, bus_wdata = 0.
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: lane pair addr[1].
  - Extension is sign or zero per req_unsigned; a word is passed through.
- rsp_rdata is 0 for stores and for any error.
- Ignored inputs:
  - bus_ack in IDLE or RESP.
  - req_* changes while in BUS or RESP; the latched copy is used.
- bus_addr = {addr[31:2], 00}.

Test Plan:
- Load byte, addr 0x1003, req_unsigned = 0, bus_rdata 0x80FF_1234, ack on first BUS cycle:
  - bus_be = 1111, bus_addr = 0x1000.
  - rsp_rdata = 0xFFFF_FF80, rsp_err = 0.
  - req_stall high for exactly 2 cycles.
- Repeat the previous load with req_unsigned = 1, addr 0x1002 -> rsp_rdata = 0x0000_00FF.
- Store half, addr 0x2002, wdata 0xDEAD_BEEF, ack delayed 3 cycles:
  - bus_be = 1100, bus_wdata = 0xBEEF_BEEF, bus_we = 1.
  - Bus signals stable for 4 cycles; then rsp_valid with rsp_rdata = 0.
- Load word at 0x3001 -> no bus_req; rsp_valid with rsp_err = 1 one cycle after acceptance. Repeat with req_size = 11 -> same result.
- MAX_WAIT = 4, load with bus_ack held 0:
  - bus_req high for 4 cycles, then drops.
  - rsp_err = 1, rsp_rdata = 0.
  - A late ack afterwards is ignored.
- Reset asserted during BUS -> all outputs 0 at that edge, no rsp_valid. A store byte at 0x0001 after reset -> bus_be = 0010.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data bus between the M-stage memory access unit and the data memory.
// Word-addressed req/ack bus with per-byte enables.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage data memory access: store lane steering, load extraction,
// req/ack bus handshake with timeout, and pipeline stall generation.
module mem_access_unit #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  lat_size_q, lat_size_d;
    logic        lat_uns_q, lat_uns_d;
    logic [1:0]  lat_lo_q, lat_lo_d;

    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        bad_req;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Alignment and reserved-size check on the live request
    always_comb begin
        bad_req = 1'b0;
        unique case (req_size)
            2'b00:   bad_req = 1'b0;
            2'b01:   bad_req = req_addr[0];
            2'b10:   bad_req = |req_addr[1:0];
            default: bad_req = 1'b1;
        endcase
    end

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'd0;
        if (req_we) begin
            unique case (req_size)
                2'b00: begin
                    st_be    = 4'b0001 << req_addr[1:0];
                    st_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = req_wdata;
                end
            endcase
        end
    end

    // Load lane select uses the latched address, not the live one
    always_comb begin
        ld_byte = bus.bus_rdata[7:0];
        unique case (lat_lo_q)
            2'b00: ld_byte = bus.bus_rdata[7:0];
            2'b01: ld_byte = bus.bus_rdata[15:8];
            2'b10: ld_byte = bus.bus_rdata[23:16];
            2'b11: ld_byte = bus.bus_rdata[31:24];
        endcase
        ld_half = lat_lo_q[1] ? bus.bus_rdata[31:16]
                              : bus.bus_rdata[15:0];
        unique case (lat_size_q)
            2'b00:   ld_ext = {{24{~lat_uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{~lat_uns_q & ld_half[15]}}, ld_half};
            default: ld_ext = bus.bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_size_d  = lat_size_q;
        lat_uns_d   = lat_uns_q;
        lat_lo_d    = lat_lo_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    lat_size_d = req_size;
                    lat_uns_d  = req_unsigned;
                    lat_lo_d   = req_addr[1:0];
                    if (bad_req) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d     = BUS;
                        cnt_d       = 8'd0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_we;
                        bus_addr_d  = {req_addr[31:2], 2'b00};
                        bus_be_d    = st_be;
                        bus_wdata_d = st_wdata;
                    end
                end
            end
            BUS: begin
                if (bus.bus_ack) begin
                    state_d     = RESP;
                    cnt_d       = 8'd0;
                    bus_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = bus_we_q ? 32'd0 : ld_ext;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d     = RESP;
                    cnt_d       = 8'd0;
                    bus_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            lat_size_q  <= 2'd0;
            lat_uns_q   <= 1'b0;
            lat_lo_q    <= 2'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_size_q  <= lat_size_d;
            lat_uns_q   <= lat_uns_d;
            lat_lo_q    <= lat_lo_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_stall     = req_valid & (state_q != RESP);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random accesses
// checked against an arithmetic model of the memory access rules.
module tb_mem_access_unit;

    localparam int MW = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if bif ();

    mem_access_unit #(.MAX_WAIT(MW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_stall    (req_stall),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .bus          (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic m_bad(input logic [1:0] size,
                                   input logic [31:0] a);
        if (size == 2'd3) return 1'b1;
        return (a % (32'd1 << size)) != 0;
    endfunction

    function automatic logic [31:0] m_be(input logic we,
                                         input logic [1:0] size,
                                         input logic [31:0] a);
        if (!we) return 32'd15;
        if (size == 2'd0) return 32'd1 << (a % 4);
        if (size == 2'd1) return 32'd3 << (a % 4);
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wd(input logic we,
                                         input logic [1:0] size,
                                         input logic [31:0] w);
        if (!we) return 32'd0;
        if (size == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (size == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_rd(input logic we,
                                         input logic [1:0] size,
                                         input logic uns,
                                         input logic [31:0] a,
                                         input logic [31:0] word);
        logic [31:0] v;
        if (we) return 32'd0;
        if (size == 2'd0) begin
            v = (word >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
            return v;
        end
        if (size == 2'd1) begin
            v = (word >> (8 * (a % 4))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
            return v;
        end
        return word;
    endfunction

    // ack_after < 0 means the bus never acknowledges
    task automatic run_access(input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr,
                              input logic [31:0] wdata,
                              input int ack_after,
                              input logic [31:0] rword);
        logic bad, tmo, done;
        int   exp_bus, stall_cnt, bus_cyc;
        logic [31:0] exp_rd;
        bad     = m_bad(size, addr);
        tmo     = !bad && (ack_after < 0 || ack_after >= MW);
        exp_bus = bad ? 0 : (tmo ? MW : ack_after + 1);
        exp_rd  = (bad || tmo) ? 32'd0
                               : m_rd(we, size, uns, addr, rword);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        stall_cnt = 0;
        bus_cyc   = 0;
        done      = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (req_stall) stall_cnt++;
            if (bif.bus_req) begin
                bus_cyc++;
                chk("bus_we", 32'(bif.bus_we), 32'(we));
                chk("bus_addr", bif.bus_addr, addr & 32'hFFFF_FFFC);
                chk("bus_be", 32'(bif.bus_be), m_be(we, size, addr));
                chk("bus_wdata", bif.bus_wdata, m_wd(we, size, wdata));
                bif.bus_ack   = (bus_cyc == ack_after + 1);
                bif.bus_rdata = bif.bus_ack ? rword : $urandom;
            end else begin
                bif.bus_ack   = 1'($urandom % 2);
                bif.bus_rdata = $urandom;
            end
            if (rsp_valid) begin
                chk("rsp_err", 32'(rsp_err), 32'(bad || tmo));
                chk("rsp_rdata", rsp_rdata, exp_rd);
                done = 1'b1;
            end
            @(negedge clk);
        end
        chk("rsp_done", 32'(done), 32'd1);
        chk("stall_cycles", stall_cnt, exp_bus + 1);
        chk("bus_cycles", bus_cyc, exp_bus);
        req_valid   = 1'b0;
        bif.bus_ack = 1'b0;
        #1;
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          ack;
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req", 32'(bif.bus_req), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_bus_be", 32'(bif.bus_be), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_stall", 32'(req_stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_access(1'b0, 2'd0, 1'b0, 32'h1003, 32'd0, 0, 32'h80FF_1234);
        run_access(1'b0, 2'd0, 1'b1, 32'h1002, 32'd0, 0, 32'h80FF_1234);
        run_access(1'b1, 2'd1, 1'b0, 32'h2002, 32'hDEAD_BEEF, 3, 32'd0);
        run_access(1'b0, 2'd2, 1'b0, 32'h3001, 32'd0, 0, 32'h1111_2222);
        run_access(1'b0, 2'd3, 1'b0, 32'h3000, 32'd0, 0, 32'h1111_2222);
        run_access(1'b0, 2'd2, 1'b0, 32'h3004, 32'd0, -1, 32'h1111_2222);

        // late ack after a timeout must not produce a response
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("late_ack_rsp", 32'(rsp_valid), 32'd0);
            chk("late_ack_req", 32'(bif.bus_req), 32'd0);
        end
        bif.bus_ack = 1'b0;
        @(negedge clk);

        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h4000;
        @(negedge clk);
        #1;
        chk("pre_rst_bus_req", 32'(bif.bus_req), 32'd1);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_bus_req", 32'(bif.bus_req), 32'd0);
        chk("mid_rst_bus_we", 32'(bif.bus_we), 32'd0);
        chk("mid_rst_bus_addr", bif.bus_addr, 32'd0);
        chk("mid_rst_bus_be", 32'(bif.bus_be), 32'd0);
        chk("mid_rst_bus_wdata", bif.bus_wdata, 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset       = 1'b1;
        bif.bus_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        bif.bus_ack = 1'b0;
        @(negedge clk);
        run_access(1'b1, 2'd0, 1'b0, 32'h0001, 32'h0000_005A, 0, 32'd0);

        for (int n = 0; n < 40; n++) begin
            sz = 2'($urandom % 4);
            a  = $urandom;
            if ($urandom % 3 != 0 && sz != 2'd3)
                a = a & ~((32'd1 << sz) - 32'd1);
            ack = ($urandom % 8 == 0) ? -1 : int'($urandom % 4);
            run_access(1'($urandom), sz, 1'($urandom), a, $urandom,
                       ack, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
